mem_access_stage: RTL and testbench

MEM-stage data-memory access unit of the 5-stage pipeline. It sits between the EX/MEM register and the MEM/WB register. It performs byte/halfword/word loads and stores against an internal word-addressed data memory with configurable access latency. It stalls upstream stages while an access is in flight and presents registered results, including aligned and extended load data, to the MEM/WB register.

---
 rtl/mem_access_stage_if.sv | 46 ++++
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// Bundles the EX/MEM-side request and the MEM/WB-side result of the MEM-stage
// data-memory access unit.
//   Request (master -> slave):
//     valid_i, mem_read_i, mem_write_i, size_i[1:0], sign_ext_i,
//     addr_i[31:0], wdata_i[31:0], reg_write_i, mem_to_reg_i, write_reg_i[4:0]
//   Response (slave -> master):
//     stall_o (combinational), valid_o, reg_write_o, mem_to_reg_o,
//     read_data_o[31:0], alu_result_o[31:0], write_reg_o[4:0], misalign_o
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [1:0]  size_i;
    logic        sign_ext_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        reg_write_i;
    logic        mem_to_reg_i;
    logic [4:0]  write_reg_i;

    logic        stall_o;
    logic        valid_o;
    logic        reg_write_o;
    logic        mem_to_reg_o;
    logic [31:0] read_data_o;
    logic [31:0] alu_result_o;
    logic [4:0]  write_reg_o;
    logic        misalign_o;

    modport master (
        output valid_i, mem_read_i, mem_write_i, size_i, sign_ext_i,
               addr_i, wdata_i, reg_write_i, mem_to_reg_i, write_reg_i,
        input  stall_o, valid_o, reg_write_o, mem_to_reg_o,
               read_data_o, alu_result_o, write_reg_o, misalign_o
    );

    modport slave (
        input  valid_i, mem_read_i, mem_write_i, size_i, sign_ext_i,
               addr_i, wdata_i, reg_write_i, mem_to_reg_i, write_reg_i,
        output stall_o, valid_o, reg_write_o, mem_to_reg_o,
               read_data_o, alu_result_o, write_reg_o, misalign_o
    );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM-stage data-memory access unit. Performs byte/half/word loads and stores
// against an internal little-endian word array, holds the upstream pipeline
// (stall_o) while a multi-cycle access is in flight, and registers the
// extended load data and pass-through controls for the MEM/WB register.
//
// Parameters:
//   MEM_WORDS : data memory depth in 32-bit words (power of 2)
//   LATENCY   : cycles one memory access occupies the stage (>= 1)
// Ports:
//   clk_i     : clock, all state on rising edge
//   rst_i     : synchronous active-high reset (FSM, outputs, memory array)
//   bus       : mem_access_stage_if.slave request/response bundle
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_access_stage_if.slave bus
);
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam bit MULTI = (LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      mem [MEM_WORDS];

    logic          mem_op;
    logic          aligned;
    logic          start_multi;
    logic          stall;
    logic          do_load;
    logic          do_store;
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        unique case (size)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the store data across lanes, then keep only the selected lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] lanes;
        logic [31:0] res;
        logic [3:0]  m;
        unique case (size)
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        m = lane_mask(size, lo);
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = m[b] ? lanes[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    // Select the addressed byte/half and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic sgn);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = word >> {lo, 3'b000};
        half    = lo[1] ? word[31:16] : word[15:0];
        unique case (size)
            2'b00:   res = {{24{sgn & shifted[7]}}, shifted[7:0]};
            2'b01:   res = {{16{sgn & half[15]}}, half};
            default: res = word;
        endcase
        return res;
    endfunction

    assign mem_op   = bus.valid_i & (bus.mem_read_i | bus.mem_write_i);
    assign word_idx = bus.addr_i[AW+1:2];
    assign cur_word = mem[word_idx];

    always_comb begin
        unique case (bus.size_i)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~bus.addr_i[0];
            default: aligned = (bus.addr_i[1:0] == 2'b00);
        endcase
    end

    // Read+write together is a store; the load path is suppressed.
    assign do_store = mem_op & aligned & bus.mem_write_i;
    assign do_load  = mem_op & aligned & bus.mem_read_i & ~bus.mem_write_i;

    assign start_multi = (state == IDLE) & mem_op & aligned & MULTI;
    assign stall       = start_multi | ((state == BUSY) & (cnt != '0));
    assign bus.stall_o = stall;

    // Any cycle without stall is a completion cycle: the array commits and the
    // output registers capture the instruction; stalled cycles emit bubbles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.valid_o      <= 1'b0;
            bus.reg_write_o  <= 1'b0;
            bus.mem_to_reg_o <= 1'b0;
            bus.read_data_o  <= '0;
            bus.alu_result_o <= '0;
            bus.write_reg_o  <= '0;
            bus.misalign_o   <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_multi) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (stall) begin
                bus.valid_o      <= 1'b0;
                bus.reg_write_o  <= 1'b0;
                bus.mem_to_reg_o <= 1'b0;
                bus.read_data_o  <= '0;
                bus.alu_result_o <= '0;
                bus.write_reg_o  <= '0;
                bus.misalign_o   <= 1'b0;
            end else begin
                bus.valid_o      <= bus.valid_i;
                bus.reg_write_o  <= bus.valid_i & bus.reg_write_i & ~(mem_op & ~aligned);
                bus.mem_to_reg_o <= bus.valid_i & bus.mem_to_reg_i;
                bus.alu_result_o <= bus.valid_i ? bus.addr_i : '0;
                bus.write_reg_o  <= bus.valid_i ? bus.write_reg_i : '0;
                bus.misalign_o   <= mem_op & ~aligned;
                bus.read_data_o  <= do_load
                                    ? load_extract(cur_word, bus.size_i, bus.addr_i[1:0], bus.sign_ext_i)
                                    : '0;
                if (do_store) begin
                    mem[word_idx] <= store_merge(cur_word, bus.wdata_i, bus.size_i, bus.addr_i[1:0]);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Scoreboard bench for mem_access_stage. dut_a (LATENCY=2) receives directed
// and random traffic whose expected results come from a byte-array reference
// model; a monitor pops expectations whenever valid_o is seen. dut_b
// (LATENCY=4) exercises reset during an in-flight store.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;
    localparam int          LAT_A     = 2;
    localparam int          LAT_B     = 4;
    localparam int unsigned MEM_BYTES = 256 * 4;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mtr;
        logic        mis;
        logic [4:0]  wreg;
        logic [31:0] alu;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic        mtr;
        logic [4:0]  wreg;
    } op_t;

    logic clk;
    logic rst_a;
    logic rst_b;

    mem_access_stage_if ifa ();
    mem_access_stage_if ifb ();

    mem_access_stage #(.MEM_WORDS(256), .LATENCY(LAT_A)) dut_a (.clk_i(clk), .rst_i(rst_a), .bus(ifa));
    mem_access_stage #(.MEM_WORDS(256), .LATENCY(LAT_B)) dut_b (.clk_i(clk), .rst_i(rst_b), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t mon_act;
    exp_t mon_exp;
    logic [7:0] mem_m [MEM_BYTES];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Reference model: byte-addressed little-endian memory with address wrap.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int unsigned n;
        int unsigned base;
        logic [31:0] val;
        e = '0;
        if (!op.valid) return e;
        e.valid = 1'b1;
        e.rw    = op.rw;
        e.mtr   = op.mtr;
        e.wreg  = op.wreg;
        e.alu   = op.addr;
        if (!(op.rd || op.wr)) return e;
        n = nbytes(op.size);
        if ((op.addr % n) != 0) begin
            e.mis = 1'b1;
            e.rw  = 1'b0;
            return e;
        end
        base = op.addr % MEM_BYTES;
        if (op.wr) begin
            for (int i = 0; i < int'(n); i++) mem_m[base + i] = 8'(op.wdata >> (8 * i));
        end else begin
            val = '0;
            for (int i = 0; i < int'(n); i++) val = val | (32'(mem_m[base + i]) << (8 * i));
            if (op.sgn && n < 4 && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
            e.rdata = val;
        end
        return e;
    endfunction

    function automatic op_t mk(input logic valid, input logic rd, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rw, input logic mtr, input logic [4:0] wreg);
        op_t o;
        o.valid = valid; o.rd = rd; o.wr = wr; o.size = size; o.sgn = sgn;
        o.addr = addr; o.wdata = wdata; o.rw = rw; o.mtr = mtr; o.wreg = wreg;
        return o;
    endfunction

    function automatic exp_t snap_a();
        exp_t a;
        a.valid = ifa.valid_o; a.rw = ifa.reg_write_o; a.mtr = ifa.mem_to_reg_o; a.mis = ifa.misalign_o;
        a.wreg = ifa.write_reg_o; a.alu = ifa.alu_result_o; a.rdata = ifa.read_data_o;
        return a;
    endfunction

    function automatic exp_t snap_b();
        exp_t a;
        a.valid = ifb.valid_o; a.rw = ifb.reg_write_o; a.mtr = ifb.mem_to_reg_o; a.mis = ifb.misalign_o;
        a.wreg = ifb.write_reg_o; a.alu = ifb.alu_result_o; a.rdata = ifb.read_data_o;
        return a;
    endfunction

    // Called at a falling edge: present op, hold through stall, return at the
    // falling edge after the completion edge.
    task automatic issue(input op_t op);
        exp_t        e;
        int unsigned want_stall;
        int unsigned n;
        ifa.valid_i      = op.valid;
        ifa.mem_read_i   = op.rd;
        ifa.mem_write_i  = op.wr;
        ifa.size_i       = op.size;
        ifa.sign_ext_i   = op.sgn;
        ifa.addr_i       = op.addr;
        ifa.wdata_i      = op.wdata;
        ifa.reg_write_i  = op.rw;
        ifa.mem_to_reg_i = op.mtr;
        ifa.write_reg_i  = op.wreg;
        want_stall = 0;
        if (op.valid && (op.rd || op.wr) && (op.addr % nbytes(op.size)) == 0) want_stall = LAT_A - 1;
        e = model(op);
        if (op.valid) exp_q.push_back(e);
        n = 0;
        #1;
        while (ifa.stall_o === 1'b1 && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("stall_cycles", 80'(n), 80'(want_stall));
        @(negedge clk);
    endtask

    function automatic op_t rand_op();
        op_t         o;
        int unsigned k;
        o.valid = ($urandom_range(0, 7) != 0);
        k = $urandom_range(0, 9);
        o.rd = (k >= 2 && k <= 5) || k == 9;
        o.wr = (k >= 6);
        o.size  = 2'($urandom_range(0, 3));
        o.sgn   = 1'($urandom_range(0, 1));
        o.addr  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
        o.wdata = $urandom;
        o.rw    = 1'($urandom_range(0, 1));
        o.mtr   = 1'($urandom_range(0, 1));
        o.wreg  = 5'($urandom_range(0, 31));
        return o;
    endfunction

    // Monitor: every output slot is either a bubble or the next expected result.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = snap_a();
            if (ifa.valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected no output", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("result", 80'(mon_act), 80'(mon_exp));
                end
            end else begin
                check("bubble", 80'(mon_act), 80'(0));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        for (int i = 0; i < int'(MEM_BYTES); i++) mem_m[i] = 8'h00;
        ifa.valid_i = 0; ifa.mem_read_i = 0; ifa.mem_write_i = 0; ifa.size_i = 0; ifa.sign_ext_i = 0;
        ifa.addr_i = 0; ifa.wdata_i = 0; ifa.reg_write_i = 0; ifa.mem_to_reg_i = 0; ifa.write_reg_i = 0;
        ifb.valid_i = 0; ifb.mem_read_i = 0; ifb.mem_write_i = 0; ifb.size_i = 0; ifb.sign_ext_i = 0;
        ifb.addr_i = 0; ifb.wdata_i = 0; ifb.reg_write_i = 0; ifb.mem_to_reg_i = 0; ifb.write_reg_i = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        mon_en = 1'b1;
        #1;
        check("reset_stall_a", 80'(ifa.stall_o), 80'(0));
        check("reset_out_a", 80'(snap_a()), 80'(0));
        check("reset_stall_b", 80'(ifb.stall_o), 80'(0));
        @(negedge clk);

        // Word store then load.
        issue(mk(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 5'd0));
        issue(mk(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 1, 5'd5));
        // Byte/half extension over 0x80F07F81.
        issue(mk(1, 0, 1, 2'd2, 0, 32'h20, 32'h80F07F81, 0, 0, 5'd0));
        issue(mk(1, 1, 0, 2'd0, 1, 32'h20, 32'h0, 1, 1, 5'd1));
        issue(mk(1, 1, 0, 2'd0, 0, 32'h23, 32'h0, 1, 1, 5'd2));
        issue(mk(1, 1, 0, 2'd1, 1, 32'h22, 32'h0, 1, 1, 5'd3));
        issue(mk(1, 1, 0, 2'd1, 0, 32'h20, 32'h0, 1, 1, 5'd4));
        // Partial stores over a cleared word (byte 0x21 is lane 1).
        issue(mk(1, 0, 1, 2'd2, 0, 32'h20, 32'h0, 0, 0, 5'd0));
        issue(mk(1, 0, 1, 2'd0, 0, 32'h21, 32'hFFFF_FFAA, 0, 0, 5'd0));
        issue(mk(1, 0, 1, 2'd1, 0, 32'h22, 32'hFFFF_1234, 0, 0, 5'd0));
        issue(mk(1, 1, 0, 2'd2, 0, 32'h20, 32'h0, 1, 1, 5'd6));
        // Wrap and pass-through.
        issue(mk(1, 0, 1, 2'd2, 0, 32'h400, 32'h55, 0, 0, 5'd0));
        issue(mk(1, 1, 0, 2'd2, 0, 32'h000, 32'h0, 1, 1, 5'd7));
        issue(mk(1, 0, 0, 2'd0, 0, 32'h7, 32'h0, 1, 0, 5'd9));
        // Misaligned accesses, then confirm memory untouched.
        issue(mk(1, 1, 0, 2'd2, 0, 32'h06, 32'h0, 1, 1, 5'd8));
        issue(mk(1, 0, 1, 2'd1, 0, 32'h03, 32'hBEEF, 1, 0, 5'd10));
        issue(mk(1, 1, 0, 2'd2, 0, 32'h00, 32'h0, 1, 1, 5'd11));
        issue(mk(1, 1, 0, 2'd2, 0, 32'h04, 32'h0, 1, 1, 5'd12));
        // Read+write together acts as a store; bubble slot.
        issue(mk(1, 1, 1, 2'd2, 0, 32'h30, 32'hCAFEF00D, 1, 1, 5'd13));
        issue(mk(0, 1, 0, 2'd2, 0, 32'h30, 32'h0, 1, 1, 5'd14));
        issue(mk(1, 1, 0, 2'd2, 0, 32'h30, 32'h0, 1, 1, 5'd15));

        for (int i = 0; i < 400; i++) issue(rand_op());
        issue(mk(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 0, 5'd0));

        // dut_b: reset on the second stall cycle of a store.
        ifb.valid_i = 1; ifb.mem_write_i = 1; ifb.size_i = 2'd2; ifb.addr_i = 32'h40; ifb.wdata_i = 32'h1;
        #1;
        check("b_stall_1", 80'(ifb.stall_o), 80'(1));
        @(negedge clk);
        #1;
        check("b_stall_2", 80'(ifb.stall_o), 80'(1));
        check("b_bubble", 80'(snap_b()), 80'(0));
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        ifb.valid_i = 0; ifb.mem_write_i = 0; ifb.wdata_i = 0;
        #1;
        check("b_rst_out", 80'(snap_b()), 80'(0));
        check("b_rst_stall", 80'(ifb.stall_o), 80'(0));
        // A non-memory op completes at once only if the FSM is idle.
        ifb.valid_i = 1; ifb.reg_write_i = 1; ifb.write_reg_i = 5'd3; ifb.addr_i = 32'h44;
        #1;
        check("b_idle_stall", 80'(ifb.stall_o), 80'(0));
        @(negedge clk);
        #1;
        check("b_nonmem_out", 80'(snap_b()), 80'({1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h44, 32'h0}));
        ifb.mem_read_i = 1; ifb.mem_to_reg_i = 1; ifb.addr_i = 32'h40; ifb.write_reg_i = 5'd4;
        n = 0;
        #1;
        while (ifb.stall_o === 1'b1 && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b_load_stall", 80'(n), 80'(LAT_B - 1));
        @(negedge clk);
        #1;
        check("b_load_out", 80'(snap_b()), 80'({1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h40, 32'h0}));
        ifb.valid_i = 0;

        repeat (2) @(negedge clk);
        check("queue_drained", 80'(exp_q.size()), 80'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
